uart_rx_to_bus: RTL and testbench
=================================

Name: uart_rx_to_bus

Overview:
- Inbound counterpart of the bus-to-UART transmit path.
- Deserialises bytes arriving on the external UART line and buffers them in a small FIFO.
- Acts as a bus initiator: writes each byte to a fixed slave address over the bit-serial system bus (ADN address bits then N data bits, MSB first).
- Sits between the external RX pin and the bus arbiter/slave fabric.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud).
- N, 8, data bits per UART frame and per bus write.
- ADN, 12, bus address width.
- DEST_ADDR, 12'h000, slave address written for every byte.
- FIFO_DEPTH, 4, byte buffer depth (power of two).
- ACK_TIMEOUT, 64, cycles to wait for ack before retrying.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- rx_in  input  1  external UART line, idle high, asynchronous to clk
- BusGrant  input  1  arbiter grant for this initiator
- ack  input  1  slave write acknowledge (1-cycle pulse)
- BusRequest  output  1  bus request to arbiter
- validOut  output  1  address/data bit on the bus is valid
- wren  output  1  write enable, high during address and data phases
- AddressOut  output  1  serial address bit
- DataOut  output  1  serial data bit
- rx_data  output  N  last received byte (debug)
- rx_error  output  1  1-cycle pulse on framing (or parity) error
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full
- state_out  output  3  current bus FSM state encoding

Behaviour:
- Reset (reset==0 at a clk edge), all outputs 0 except rx_data=0 and state_out=B_IDLE:
  - FIFO emptied; overflow cleared.
  - Synchronizer flops set to 1.
  - Reset mid-frame or mid-transfer aborts immediately; no partial bus write completes.
- rx_in passes through a 2-flop synchronizer before any use.
- RX FSM:
  - R_IDLE: wait for synced rx low → R_START.
  - R_START: count CLKS_PER_BIT/2. If line still low → R_DATA; else glitch → R_IDLE, no error.
  - R_DATA: sample every CLKS_PER_BIT; N bits, LSB first, into a shift register.
  - R_STOP: sample after CLKS_PER_BIT.
    - Line = 1: push byte to FIFO and update rx_data.
    - Line = 0: pulse rx_error, discard byte.
  - R_CLEAN: 1 cycle → R_IDLE.
  - Byte is visible in the FIFO 1 cycle after the stop-bit sample.
- FIFO:
  - Push when full: byte dropped, overflow set.
  - Simultaneous push and pop when full: both succeed.
  - Pop only in B_DONE.
- Bus FSM (state_out encoding 0..5):
  - B_IDLE: FIFO non-empty → B_REQ.
  - B_REQ: BusRequest=1 until BusGrant=1; enter B_ADDR on the following cycle.
  - B_ADDR: ADN cycles, validOut=1, wren=1, AddressOut = DEST_ADDR MSB first.
  - B_DATA: N cycles, validOut=1, wren=1, DataOut = FIFO head MSB first.
  - B_WAIT: validOut=0, BusRequest held. ack → B_DONE. Timeout counter reaches ACK_TIMEOUT → B_REQ (full retry, byte kept).
  - B_DONE: 1 cycle; pop FIFO, drop BusRequest → B_IDLE.
  - BusRequest stays high from B_REQ through B_WAIT.
  - BusGrant deasserted during B_ADDR/B_DATA/B_WAIT: abort, outputs to 0, → B_REQ, whole frame resent.
  - ack outside B_WAIT is ignored.
  - Minimum bus write latency after grant: ADN+N+1 cycles to ack sampling.
- RX path and bus path run concurrently; reception never stalls.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - R_PARITY state between R_DATA and R_STOP samples an even-parity bit.
  - Mismatch → rx_error pulse at stop-bit time and byte discarded, even if the stop bit is good.
- Undefined: no parity state; frame is 1 start, N data, 1 stop.

Decomposition:
- Package uart_rx_pkg: RX state enum, bus state enum (with fixed encodings for state_out), FIFO pointer width function.
- One sub-module, uart_rx_core: synchronizer, RX FSM, bit counter, N-bit byte output with a 1-cycle byte_valid and err pulse.
- FIFO and bus FSM live in the top module.

Test Plan (bench sets CLKS_PER_BIT=16, DEST_ADDR=12'hA5C):
- Send 8'h3C, grant held high, ack 2 cycles after data → bus shows addr bits 101001011100 then data 00111100, validOut high 20 cycles; FIFO empty after B_DONE.
- Stop bit driven 0 on byte 8'hFF → rx_error pulses once; no BusRequest.
- 6 back-to-back bytes with BusGrant held low → first 4 buffered, overflow=1. Then grant → exactly 4 writes, in order.
- Drop BusGrant in data bit 3 → abort to B_REQ; on re-grant the full 20-bit frame is resent with the same byte.
- Never ack → retry after 64 cycles in B_WAIT. Ack on second attempt → single pop.
- 1/4-bit-wide low glitch on rx_in → no byte, no error. With UART_RX_PARITY_EN, wrong parity on 8'h01 → rx_error, byte discarded.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive-to-bus bridge: RX and bus FSM state
// enums (bus encodings are exported on state_out) and FIFO pointer sizing.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_START  = 3'd1,
        R_DATA   = 3'd2,
        R_PARITY = 3'd3,
        R_STOP   = 3'd4,
        R_CLEAN  = 3'd5
    } rx_state_t;

    typedef enum logic [2:0] {
        B_IDLE = 3'd0,
        B_REQ  = 3'd1,
        B_ADDR = 3'd2,
        B_DATA = 3'd3,
        B_WAIT = 3'd4,
        B_DONE = 3'd5
    } bus_state_t;

    // Bits needed to index a power-of-two FIFO of the given depth (minimum 1).
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, start-bit qualification, LSB-first data,
// optional even-parity bit (UART_RX_PARITY_EN) and stop-bit check.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned N            = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_in,
    output logic [N-1:0] byte_out,
    output logic         byte_valid,
    output logic         err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW = $clog2(N + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = R_PARITY;
`else
    localparam rx_state_t AFTER_DATA = R_STOP;
`endif

    logic          sync1;
    logic          sync2;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  shreg;
    logic          half_tick;
    logic          bit_tick;
    logic          par_ok;

    assign half_tick = (clk_cnt == HALF_LAST);
    assign bit_tick  = (clk_cnt == BIT_LAST);
    assign byte_out  = shreg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (state == R_PARITY && bit_tick) begin
            par_bit <= sync2;
        end
    end

    assign par_ok = (par_bit == ^shreg);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= R_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_next;
            // The sample counter restarts on every state change and every bit boundary.
            if (state == R_IDLE || state_next != state || bit_tick) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (state != R_DATA) begin
                bit_cnt <= '0;
            end else if (bit_tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == R_DATA && bit_tick) begin
                shreg <= {sync2, shreg[N-1:1]};
            end
        end
    end

    always_comb begin
        state_next = state;
        byte_valid = 1'b0;
        err        = 1'b0;
        case (state)
            R_IDLE: begin
                if (!sync2) state_next = R_START;
            end
            R_START: begin
                if (half_tick) state_next = sync2 ? R_IDLE : R_DATA;
            end
            R_DATA: begin
                if (bit_tick && bit_cnt == DATA_LAST) state_next = AFTER_DATA;
            end
            R_PARITY: begin
                if (bit_tick) state_next = R_STOP;
            end
            R_STOP: begin
                if (bit_tick) begin
                    state_next = R_CLEAN;
                    if (sync2 && par_ok) begin
                        byte_valid = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            R_CLEAN: state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_to_bus.sv
// UART receive-to-bus bridge: buffers received bytes in a FIFO and writes each
// one to DEST_ADDR over the bit-serial bus. Parity option: UART_RX_PARITY_EN.
module uart_rx_to_bus
    import uart_rx_pkg::*;
#(
    parameter int unsigned    CLKS_PER_BIT = 5208,
    parameter int unsigned    N            = 8,
    parameter int unsigned    ADN          = 12,
    parameter logic [ADN-1:0] DEST_ADDR    = '0,
    parameter int unsigned    FIFO_DEPTH   = 4,
    parameter int unsigned    ACK_TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_in,
    input  logic         BusGrant,
    input  logic         ack,
    output logic         BusRequest,
    output logic         validOut,
    output logic         wren,
    output logic         AddressOut,
    output logic         DataOut,
    output logic [N-1:0] rx_data,
    output logic         rx_error,
    output logic         overflow,
    output logic [2:0]   state_out
);

    localparam int unsigned PW = ptr_width(FIFO_DEPTH);
    localparam int unsigned SW = $clog2(((ADN > N) ? ADN : N) + 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] ADDR_LAST = SW'(ADN - 1);
    localparam logic [SW-1:0] DATA_LAST = SW'(N - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(ACK_TIMEOUT - 1);

    logic [N-1:0] byte_out;
    logic         byte_valid;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .N           (N)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .err       (rx_error)
    );

    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          wr_en;
    logic [N-1:0]  head;

    bus_state_t    bstate;
    bus_state_t    bstate_next;
    logic [SW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic [ADN-1:0] addr_sh;
    logic [N-1:0]  data_sh;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign pop   = (bstate == B_DONE);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_en = byte_valid && (!full || pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= byte_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rx_data  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (byte_valid && full && !pop) overflow <= 1'b1;
            if (byte_valid) rx_data <= byte_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bstate  <= B_IDLE;
            bcnt    <= '0;
            tcnt    <= '0;
            addr_sh <= '0;
            data_sh <= '0;
        end else begin
            bstate <= bstate_next;
            if (bstate_next != bstate) begin
                bcnt <= '0;
            end else if (bstate == B_ADDR || bstate == B_DATA) begin
                bcnt <= bcnt + 1'b1;
            end
            if (bstate == B_WAIT && bstate_next == B_WAIT) begin
                tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end
            // Frame is reloaded on every grant so an aborted or timed-out write resends in full.
            if (bstate == B_REQ && BusGrant) begin
                addr_sh <= DEST_ADDR;
                data_sh <= head;
            end else begin
                if (bstate == B_ADDR) addr_sh <= {addr_sh[ADN-2:0], 1'b0};
                if (bstate == B_DATA) data_sh <= {data_sh[N-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        bstate_next = bstate;
        BusRequest  = 1'b0;
        validOut    = 1'b0;
        wren        = 1'b0;
        AddressOut  = 1'b0;
        DataOut     = 1'b0;
        case (bstate)
            B_IDLE: begin
                if (!empty) bstate_next = B_REQ;
            end
            B_REQ: begin
                BusRequest = 1'b1;
                if (BusGrant) bstate_next = B_ADDR;
            end
            B_ADDR: begin
                BusRequest = 1'b1;
                validOut   = 1'b1;
                wren       = 1'b1;
                AddressOut = addr_sh[ADN-1];
                if (!BusGrant) begin
                    bstate_next = B_REQ;
                end else if (bcnt == ADDR_LAST) begin
                    bstate_next = B_DATA;
                end
            end
            B_DATA: begin
                BusRequest = 1'b1;
                validOut   = 1'b1;
                wren       = 1'b1;
                DataOut    = data_sh[N-1];
                if (!BusGrant) begin
                    bstate_next = B_REQ;
                end else if (bcnt == DATA_LAST) begin
                    bstate_next = B_WAIT;
                end
            end
            B_WAIT: begin
                BusRequest = 1'b1;
                if (!BusGrant) begin
                    bstate_next = B_REQ;
                end else if (ack) begin
                    bstate_next = B_DONE;
                end else if (tcnt == TOUT_LAST) begin
                    bstate_next = B_REQ;
                end
            end
            B_DONE: bstate_next = B_IDLE;
            default: bstate_next = B_IDLE;
        endcase
    end

    assign state_out = bstate;

endmodule

// File: tb/tb_uart_rx_to_bus.sv
// Scoreboard bench for uart_rx_to_bus; parity case runs when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_to_bus;

    localparam int unsigned CPB  = 16;
    localparam int unsigned NB   = 8;
    localparam int unsigned AW   = 12;
    localparam logic [11:0] DEST = 12'hA5C;
    localparam int unsigned TMO  = 64;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       rx_in    = 1'b1;
    logic       BusGrant = 1'b0;
    logic       ack      = 1'b0;
    logic       BusRequest;
    logic       validOut;
    logic       wren;
    logic       AddressOut;
    logic       DataOut;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       overflow;
    logic [2:0] state_out;

    int errors      = 0;
    int checks      = 0;
    int frames_done = 0;
    int aborts      = 0;
    int rx_err_cnt  = 0;
    int ack_ignore  = 0;
    logic [7:0] exp_q[$];
    int wait_lens[$];

    uart_rx_to_bus #(
        .CLKS_PER_BIT(CPB),
        .N           (NB),
        .ADN         (AW),
        .DEST_ADDR   (DEST),
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .BusGrant  (BusGrant),
        .ack       (ack),
        .BusRequest(BusRequest),
        .validOut  (validOut),
        .wren      (wren),
        .AddressOut(AddressOut),
        .DataOut   (DataOut),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .overflow  (overflow),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit par, input bit stop);
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par;
        tick(CPB);
`else
        if (par) rx_in = 1'b1;
`endif
        rx_in = stop;
        tick(CPB);
        rx_in = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        send_bits(b, ^b, stop);
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int n;
        n = 0;
        while (state_out !== s && n < limit) begin
            tick(1);
            n++;
        end
        if (state_out !== s) begin
            checks++;
            errors++;
            $display("FAIL %s: state_out=%0d expected %0d within %0d cycles", name, state_out, s, limit);
        end
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d writes outstanding, expected 0 within %0d cycles", name, exp_q.size(), limit);
        end
    endtask

    // Monitor: assembles serial frames, compares against the scoreboard head, pops on B_DONE.
    initial begin : monitor
        int nbits;
        int wlen;
        logic [11:0] a;
        logic [7:0] d;
        logic [7:0] last_d;
        nbits = 0;
        wlen = 0;
        a = '0;
        d = '0;
        last_d = '0;
        forever begin
            @(negedge clk);
            if (validOut) begin
                if (!wren) begin
                    checks++;
                    errors++;
                    $display("FAIL wren_during_valid: got 0 expected 1");
                end
                if (nbits < AW) a = {a[10:0], AddressOut};
                else d = {d[6:0], DataOut};
                nbits++;
            end else if (nbits != 0) begin
                if (nbits == AW + NB) begin
                    check("frame_addr", 32'(a), 32'(DEST));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got data %0h, expected no write", d);
                    end else begin
                        check("frame_data", 32'(d), 32'(exp_q[0]));
                    end
                    last_d = d;
                end else begin
                    aborts++;
                end
                nbits = 0;
            end
            if (rx_error) rx_err_cnt++;
            if (state_out == 3'd4) begin
                wlen++;
            end else if (wlen != 0) begin
                wait_lens.push_back(wlen);
                wlen = 0;
            end
            if (state_out == 3'd5) begin
                check("done_busreq", 32'(BusRequest), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got data %0h, expected no pop", last_d);
                end else begin
                    check("pop_data", 32'(last_d), 32'(exp_q.pop_front()));
                    frames_done++;
                end
            end
        end
    end

    // Slave model: acks on the second B_WAIT cycle unless told to ignore the episode.
    initial begin : ack_drv
        int wc;
        bit skip;
        wc = 0;
        skip = 1'b0;
        forever begin
            @(negedge clk);
            if (state_out == 3'd4) begin
                wc++;
                if (wc == 1) begin
                    skip = (ack_ignore > 0);
                    if (skip) ack_ignore--;
                end
                ack = (!skip && wc == 2);
            end else begin
                wc = 0;
                ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int e0;
        int f0;
        int a0;
        tick(3);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_busreq", 32'(BusRequest), 32'd0);
        check("rst_valid", 32'(validOut), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick(5);

        // Single byte, grant held high.
        BusGrant = 1'b1;
        f0 = frames_done;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        check("t1_rx_data", 32'(rx_data), 32'h3C);
        wait_drain(400, "t1_drain");
        tick(5);
        check("t1_frames", 32'(frames_done - f0), 32'd1);
        check("t1_idle_state", 32'(state_out), 32'd0);
        check("t1_idle_busreq", 32'(BusRequest), 32'd0);

        // Framing error on 8'hFF.
        e0 = rx_err_cnt;
        send_byte(8'hFF, 1'b0);
        tick(40);
        check("t2_rx_error", 32'(rx_err_cnt - e0), 32'd1);
        check("t2_busreq", 32'(BusRequest), 32'd0);
        check("t2_rx_data", 32'(rx_data), 32'h3C);

        // Six bytes with grant low: four buffered, two dropped.
        BusGrant = 1'b0;
        f0 = frames_done;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check("t3_no_overflow_yet", 32'(overflow), 32'd0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        tick(5);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_state_req", 32'(state_out), 32'd1);
        check("t3_busreq", 32'(BusRequest), 32'd1);
        check("t3_rx_data", 32'(rx_data), 32'h66);
        BusGrant = 1'b1;
        wait_drain(1000, "t3_drain");
        tick(10);
        check("t3_frames", 32'(frames_done - f0), 32'd4);
        check("t3_idle_state", 32'(state_out), 32'd0);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);

        reset = 1'b0;
        tick(2);
        check("rst2_overflow", 32'(overflow), 32'd0);
        check("rst2_state", 32'(state_out), 32'd0);
        reset = 1'b1;
        tick(5);

        // Grant dropped during data bit 3.
        f0 = frames_done;
        a0 = aborts;
        exp_q.push_back(8'h5A);
        fork
            send_byte(8'h5A, 1'b1);
        join_none
        wait_state(3'd3, 400, "t4_reach_data");
        tick(3);
        BusGrant = 1'b0;
        tick(1);
        check("t4_abort_state", 32'(state_out), 32'd1);
        check("t4_abort_valid", 32'(validOut), 32'd0);
        check("t4_abort_busreq", 32'(BusRequest), 32'd1);
        tick(3);
        BusGrant = 1'b1;
        wait_drain(400, "t4_drain");
        tick(20);
        check("t4_aborts", 32'(aborts - a0), 32'd1);
        check("t4_frames", 32'(frames_done - f0), 32'd1);

        // Ack withheld once: retry after the timeout, single pop.
        f0 = frames_done;
        wait_lens.delete();
        ack_ignore = 1;
        exp_q.push_back(8'h96);
        send_byte(8'h96, 1'b1);
        wait_drain(600, "t5_drain");
        tick(5);
        check("t5_frames", 32'(frames_done - f0), 32'd1);
        check("t5_wait_episodes", 32'(wait_lens.size()), 32'd2);
        if (wait_lens.size() > 0) check("t5_timeout_len", 32'(wait_lens[0]), 32'(TMO));

        // Quarter-bit low glitch.
        e0 = rx_err_cnt;
        f0 = frames_done;
        rx_in = 1'b0;
        tick(CPB / 4);
        rx_in = 1'b1;
        tick(60);
        check("t6_no_error", 32'(rx_err_cnt - e0), 32'd0);
        check("t6_state", 32'(state_out), 32'd0);
        check("t6_busreq", 32'(BusRequest), 32'd0);
        check("t6_frames", 32'(frames_done - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        e0 = rx_err_cnt;
        send_bits(8'h01, 1'b0, 1'b1);
        tick(40);
        check("t7_parity_error", 32'(rx_err_cnt - e0), 32'd1);
        check("t7_busreq", 32'(BusRequest), 32'd0);
        check("t7_rx_data", 32'(rx_data), 32'h96);
`endif

        tick(20);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
